// File: rtl/MD_pkg.sv
// Shared MD-engine constants and types used by the remote force receive path.
package MD_pkg;

  localparam int AXIS_TDATA_WIDTH      = 512;
  localparam int FLOAT_WIDTH           = 32;
  localparam int PARTICLE_ID_WIDTH     = 7;
  localparam int GLOBAL_CELL_ID_WIDTH  = 3;
  localparam int NUM_REMOTE_DEST_NODES = 7;

  // Bit 96 of a remote force packet marks an end-of-burst beat.
  localparam int REMOTE_FRC_PKT_LAST_BIT = 96;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0]      parid;
    logic [3*GLOBAL_CELL_ID_WIDTH-1:0] gcid;
    logic [3*FLOAT_WIDTH-1:0]          frc;
  } frc_rx_entry_t;

endpackage

// File: rtl/ring_frc_from_remote_receiver_fifo.sv
// Synchronous FIFO with registered full/empty and a first-word-fall-through head register.
module frc_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 112
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              empty_next
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]       cnt, cnt_n, cnt_kept;
  logic              push, pop;
  logic              full_q, empty_q;
  logic [DATA_W-1:0] head_q;

  always_comb begin
    push       = wr_en & ~full_q;
    pop        = rd_en & ~empty_q;
    rd_ptr_n   = rd_ptr + AW'(pop);
    cnt_kept   = cnt - (AW+1)'(pop);
    cnt_n      = cnt_kept + (AW+1)'(push);
    empty_next = (cnt_n == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      head_q  <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr_n;
      cnt     <= cnt_n;
      full_q  <= (cnt_n == (AW+1)'(DEPTH));
      empty_q <= (cnt_n == '0);
      // When the surviving queue is empty the incoming word becomes the head directly,
      // since the memory write has not landed yet.
      if (cnt_n != '0)
        head_q <= (push && cnt_kept == '0) ? din : mem[rd_ptr_n];
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign dout  = head_q;

endmodule

// File: rtl/ring_frc_from_remote_receiver.sv
// Receives remote force packets, buffers data beats, counts end markers and flags step completion.
module ring_frc_from_remote_receiver
  import MD_pkg::*;
#(
  parameter int FIFO_DEPTH           = 16,
  parameter int NUM_SRC_NODES        = NUM_REMOTE_DEST_NODES,
  parameter int FLOAT_WIDTH          = MD_pkg::FLOAT_WIDTH,
  parameter int PARTICLE_ID_WIDTH    = MD_pkg::PARTICLE_ID_WIDTH,
  parameter int GLOBAL_CELL_ID_WIDTH = MD_pkg::GLOBAL_CELL_ID_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_step_start,
  input  logic                              i_tvalid,
  output logic                              o_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]       i_tdata,
  input  logic                              i_tlast,
  output logic [3*FLOAT_WIDTH-1:0]          o_frc,
  output logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_gcid,
  output logic [PARTICLE_ID_WIDTH-1:0]      o_parid,
  output logic                              o_frc_valid,
  input  logic                              i_frc_ready,
  output logic [2:0]                        o_marker_cnt,
  output logic                              o_all_remote_frc_rcvd,
  output logic                              o_overflow_err
);
  localparam int FRC_W     = 3*FLOAT_WIDTH;
  localparam int GCID_W    = 3*GLOBAL_CELL_ID_WIDTH;
  localparam int GCID_LSB  = REMOTE_FRC_PKT_LAST_BIT + 1;
  localparam int PARID_LSB = GCID_LSB + GCID_W;
  localparam int PKT_HI    = PARID_LSB + PARTICLE_ID_WIDTH - 1;
  localparam int ENTRY_W   = PARTICLE_ID_WIDTH + GCID_W + FRC_W;
  localparam logic [2:0] NUM_SRC = 3'(NUM_SRC_NODES);

  logic               full, empty, empty_next;
  logic               accept, is_marker, push;
  logic [ENTRY_W-1:0] entry_in, entry_out;
  logic [2:0]         cnt_q, cnt_base, cnt_n;
  logic               done_q, ovf_q, ovf_n;
  logic               unused_bits;

  assign unused_bits = ^{i_tlast, i_tdata[AXIS_TDATA_WIDTH-1:PKT_HI+1]};

  assign o_tready  = ~full;
  assign accept    = i_tvalid & o_tready;
  assign is_marker = i_tdata[REMOTE_FRC_PKT_LAST_BIT];
  assign push      = accept & ~is_marker;
  assign entry_in  = {i_tdata[PARID_LSB +: PARTICLE_ID_WIDTH],
                      i_tdata[GCID_LSB +: GCID_W],
                      i_tdata[FRC_W-1:0]};

  frc_rx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (push),
    .din        (entry_in),
    .full       (full),
    .rd_en      (i_frc_ready),
    .dout       (entry_out),
    .empty      (empty),
    .empty_next (empty_next)
  );

  // A step start and a marker in the same cycle count the marker against the new step.
  always_comb begin
    cnt_base = i_step_start ? 3'd0 : cnt_q;
    cnt_n    = cnt_base;
    ovf_n    = ovf_q;
    if (accept && is_marker) begin
      if (cnt_base == NUM_SRC) ovf_n = 1'b1;
      else                     cnt_n = cnt_base + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 3'd0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_n;
      ovf_q  <= ovf_n;
      done_q <= i_step_start ? 1'b0 : (done_q | (cnt_n == NUM_SRC && empty_next));
    end
  end

  assign o_frc_valid           = ~empty;
  assign o_frc                 = entry_out[FRC_W-1:0];
  assign o_gcid                = entry_out[FRC_W +: GCID_W];
  assign o_parid               = entry_out[FRC_W+GCID_W +: PARTICLE_ID_WIDTH];
  assign o_marker_cnt          = cnt_q;
  assign o_all_remote_frc_rcvd = done_q;
  assign o_overflow_err        = ovf_q;

endmodule

// File: tb/tb_ring_frc_from_remote_receiver.sv
// Directed bench for the remote force receiver: ordering, markers, full, overflow, step start, reset.
module tb_ring_frc_from_remote_receiver;
  logic         clk = 1'b0;
  logic         rst, i_step_start, i_tvalid, i_tlast, i_frc_ready;
  logic         o_tready, o_frc_valid, o_all_remote_frc_rcvd, o_overflow_err;
  logic [511:0] i_tdata;
  logic [95:0]  o_frc;
  logic [8:0]   o_gcid;
  logic [6:0]   o_parid;
  logic [2:0]   o_marker_cnt;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ring_frc_from_remote_receiver dut (
    .clk(clk), .rst(rst), .i_step_start(i_step_start),
    .i_tvalid(i_tvalid), .o_tready(o_tready), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .o_frc(o_frc), .o_gcid(o_gcid), .o_parid(o_parid), .o_frc_valid(o_frc_valid),
    .i_frc_ready(i_frc_ready), .o_marker_cnt(o_marker_cnt),
    .o_all_remote_frc_rcvd(o_all_remote_frc_rcvd), .o_overflow_err(o_overflow_err)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [511:0] pkt(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z, input logic last,
                                      input logic [8:0] gcid, input logic [6:0] parid);
    logic [511:0] p = '0;
    p[31:0] = x; p[63:32] = y; p[95:64] = z;
    p[96] = last; p[105:97] = gcid; p[112:106] = parid;
    p[511:500] = 12'hABC;  // junk in don't-care bits
    return p;
  endfunction

  function automatic logic [511:0] dbeat(input logic [6:0] parid);
    return pkt(32'h3F800000, 32'h40000000 + 32'(parid), 32'hC0400000, 1'b0, 9'o123, parid);
  endfunction

  function automatic logic [511:0] mbeat();
    return pkt(32'h0, 32'h0, 32'h0, 1'b1, 9'h0, 7'h0);
  endfunction

  task automatic send(input logic [511:0] d);
    i_tvalid = 1'b1; i_tdata = d; tick(); i_tvalid = 1'b0;
  endtask

  initial begin
    int acc, got, cyc;
    logic [6:0] nxt;
    rst = 1'b1; i_step_start = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b1;
    i_frc_ready = 1'b0; i_tdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_tready", o_tready, 1);
    chk("rst_valid", o_frc_valid, 0);
    chk("rst_frc", o_frc, 0);
    chk("rst_gcid", o_gcid, 0);
    chk("rst_parid", o_parid, 0);
    chk("rst_cnt", o_marker_cnt, 0);
    chk("rst_done", o_all_remote_frc_rcvd, 0);
    chk("rst_ovf", o_overflow_err, 0);

    // 3 data beats with ready high: output one cycle after each accept
    i_frc_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_tvalid = 1'b1; i_tdata = dbeat(7'(5 + k)); tick();
      chk("t1_valid", o_frc_valid, 1);
      chk("t1_parid", o_parid, 7'(5 + k));
      chk("t1_frc", o_frc, {32'hC0400000, 32'h40000000 + 32'(5 + k), 32'h3F800000});
      chk("t1_gcid", o_gcid, 9'o123);
    end
    i_tvalid = 1'b0; tick();
    chk("t1_drained", o_frc_valid, 0);

    // 7 markers interleaved with 4 data beats, accumulator stalled
    i_frc_ready = 1'b0;
    nxt = 7'd20;
    for (int k = 0; k < 11; k++) begin
      if (k < 8 && k % 2 == 1) begin send(dbeat(nxt)); nxt++; end
      else send(mbeat());
    end
    chk("t2_cnt", o_marker_cnt, 7);
    chk("t2_done_early", o_all_remote_frc_rcvd, 0);
    i_frc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_parid", o_parid, 7'(20 + k));
      chk("t2_done_pre", o_all_remote_frc_rcvd, 0);
      tick();
    end
    chk("t2_done", o_all_remote_frc_rcvd, 1);
    chk("t2_empty", o_frc_valid, 0);
    chk("t2_cnt_hold", o_marker_cnt, 7);

    // 8th marker in the step
    send(mbeat());
    chk("t3_ovf", o_overflow_err, 1);
    chk("t3_cnt", o_marker_cnt, 7);
    tick();
    chk("t3_ovf_sticky", o_overflow_err, 1);

    // fill past depth with accumulator stalled, then drain
    i_frc_ready = 1'b0; acc = 0;
    for (int c = 0; c < 22; c++) begin
      i_tvalid = 1'b1; i_tdata = dbeat(7'(acc));
      if (o_tready) acc++;
      tick();
    end
    chk("t4_accepted", acc, 16);
    chk("t4_tready_low", o_tready, 0);
    chk("t4_done_kept", o_all_remote_frc_rcvd, 1);
    i_frc_ready = 1'b1; got = 0; cyc = 0;
    while (got < 18 && cyc < 60) begin
      i_tvalid = (acc < 18); i_tdata = dbeat(7'(acc));
      if (o_frc_valid) begin
        chk("t4_order", o_parid, 7'(got));
        got++;
      end
      if (i_tvalid && o_tready) acc++;
      tick(); cyc++;
    end
    i_tvalid = 1'b0;
    chk("t4_got", got, 18);
    chk("t4_empty", o_frc_valid, 0);

    // step start coincident with a marker; queued data survives
    i_frc_ready = 1'b0;
    send(dbeat(7'd40)); send(dbeat(7'd41));
    i_step_start = 1'b1; send(mbeat()); i_step_start = 1'b0;
    chk("t5_cnt", o_marker_cnt, 1);
    chk("t5_done", o_all_remote_frc_rcvd, 0);
    chk("t5_ovf_kept", o_overflow_err, 1);
    chk("t5_valid", o_frc_valid, 1);
    chk("t5_head", o_parid, 40);
    i_frc_ready = 1'b1; tick();
    chk("t5_second", o_parid, 41);
    tick();
    chk("t5_empty", o_frc_valid, 0);

    // reset with 5 entries queued
    i_frc_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(dbeat(7'(50 + k)));
    chk("t6_valid_pre", o_frc_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_valid", o_frc_valid, 0);
    chk("t6_cnt", o_marker_cnt, 0);
    chk("t6_tready", o_tready, 1);
    chk("t6_ovf", o_overflow_err, 0);
    chk("t6_parid", o_parid, 0);
    i_frc_ready = 1'b1; tick();
    chk("t6_no_ghost", o_frc_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ring_frc_from_remote_receiver.md
# ring_frc_from_remote_receiver

Receive-side counterpart of the remote force transmit path. Accepts single-beat AXI-Stream force packets arriving from the 7 neighbouring nodes, unpacks `{parid, gcid, last, frc_z, frc_y, frc_x}`, and buffers the forces in a FIFO. Each force is presented to the local force accumulation stage over a valid/ready handshake. It also counts per-step end-of-burst markers and flags when all remote forces for the current step have arrived.

## Interface

Parameters:
- `FIFO_DEPTH`, 16: force entries buffered; power of two, ≥4.
- `NUM_SRC_NODES`, 7: end markers expected per step (matches `NUM_REMOTE_DEST_NODES`).
- `FLOAT_WIDTH`, 32: width of one force component.
- `PARTICLE_ID_WIDTH`, from MD_pkg: particle id width.
- `GLOBAL_CELL_ID_WIDTH`, from MD_pkg: width of one cell coordinate.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_step_start`  in  1  one-cycle pulse; clears marker count and done flag for a new step.
- `i_tvalid`  in  1  AXIS valid from network.
- `o_tready`  out  1  AXIS ready; high when FIFO not full.
- `i_tdata`  in  `AXIS_TDATA_WIDTH`  AXIS data; only [127:0] used.
- `i_tlast`  in  1  AXIS last; ignored, every beat is a packet.
- `o_frc`  out  `3*FLOAT_WIDTH`  `{z,y,x}` force.
- `o_gcid`  out  `3*GLOBAL_CELL_ID_WIDTH`  destination cell.
- `o_parid`  out  `PARTICLE_ID_WIDTH`  destination particle.
- `o_frc_valid`  out  1  force entry available.
- `i_frc_ready`  in  1  accumulator accepts entry.
- `o_marker_cnt`  out  3  markers seen this step.
- `o_all_remote_frc_rcvd`  out  1  level; set when the count reaches `NUM_SRC_NODES` and the FIFO is empty.
- `o_overflow_err`  out  1  sticky; marker count would exceed `NUM_SRC_NODES`.

## Operation

- Beat accepted when `i_tvalid && o_tready`.
- Packet field layout:
  - [31:0] x, [63:32] y, [95:64] z.
  - [96] last marker.
  - [96+1 +: 3*GLOBAL_CELL_ID_WIDTH] gcid.
  - Next `PARTICLE_ID_WIDTH` bits: parid.
  - Remaining bits: don't-care.
- Marker beat (bit96=1):
  - Not written to FIFO.
  - Increments `o_marker_cnt`, saturating at `NUM_SRC_NODES`.
  - If a marker arrives when the count is already `NUM_SRC_NODES`, set `o_overflow_err` and leave the count unchanged.
- Data beat (bit96=0): written to FIFO as `{parid, gcid, frc}`.
- `o_tready = !full`. Marker beats are also blocked when full; the simpler rule is mandatory.
- Output side: `o_frc_valid = !empty`; pop on `o_frc_valid && i_frc_ready`. Outputs are registered FIFO head contents.
- Done condition:
  - `o_all_remote_frc_rcvd` is set when `marker_cnt == NUM_SRC_NODES && empty`.
  - It remains set until `i_step_start` or `rst`.
  - Data arriving after done is still buffered and output, but done stays set.
- `i_step_start`:
  - Clears the count and done flag.
  - Does NOT flush the FIFO; `o_overflow_err` is cleared only by `rst`.
  - If `i_step_start` and an accepted marker occur in the same cycle, the count becomes 1.
- Simultaneous push and pop when full: not possible, since ready is low when full. Push and pop when neither full nor empty: occupancy is unchanged.

## Timing

- Reset values:
  - `o_tready=1`, `o_frc_valid=0`, `o_frc/o_gcid/o_parid=0`.
  - `o_marker_cnt=0`, `o_all_remote_frc_rcvd=0`, `o_overflow_err=0`.
- Latency: data accepted at cycle N gives `o_frc_valid` at N+1 when the FIFO was empty.
- Throughput: one beat/cycle in, one entry/cycle out.
- Done asserts one cycle after the last-required condition becomes true: the final marker is accepted, or the final pop empties the FIFO.
- `o_tready` is deasserted in the cycle after occupancy reaches `FIFO_DEPTH`. It is combinational from registered `full`, so there is no beat loss.
- Reset mid-burst: all entries are dropped, pointers are zeroed, and outputs follow the reset values at the next edge.

## Structure

- MD_pkg:
  - Add a `REMOTE_FRC_PKT_LAST_BIT = 96` constant.
  - Add the typedef `frc_rx_entry_t` = `{parid, gcid, frc}`.
  - Reuse `AXIS_TDATA_WIDTH`, `FLOAT_WIDTH`, `NUM_REMOTE_DEST_NODES`.
- Sub-module `frc_rx_fifo`: a synchronous FIFO with registered full/empty and a first-word-fall-through head register. The top level holds unpack, marker counter and done logic.

## Test plan

- Reset, then 3 data beats (x=0x3F800000, gcid=`{1,2,3}`, parid=5..7) with `i_frc_ready=1` → three outputs in order starting 1 cycle after the first accept, fields bit-exact.
- 7 markers interleaved with 4 data beats, ready held low until all received, then released → done asserts only one cycle after the 4th pop; `o_marker_cnt=7`.
- Push `FIFO_DEPTH+2` beats back-to-back with `i_frc_ready=0` → `o_tready` falls after 16 accepts, no entry lost or duplicated after draining.
- 8th marker in one step → `o_overflow_err=1` (sticky), count stays 7.
- `i_step_start` coincident with an accepted marker → count=1, done=0; FIFO contents preserved.
- `rst` asserted with 5 entries queued → next cycle `o_frc_valid=0`, count 0, `o_tready=1`.
